// File: rtl/simt_core_param.sv
// ---------------------------------------------------------------------------
// simt_core_param
// Per-thread-slot SIMT core. Each instruction is fetched at pc, decoded,
// has its two operands and its predicate read from the shared files, may wait
// for a handshaked data load, and then executes. Results go out as one-cycle
// write strobes to the register file, the predicate file, the data memory or
// the dispatch queue. When a thread finishes (DONE), the core asks for a new
// start pc through a request/valid handshake.
//
// Parameters
//   DATA_W    register / memory / immediate data width (>= 16)
//   PC_W      program counter width
//   NUM_REGS  architectural registers (<= 16, indices wrap modulo NUM_REGS)
//   NUM_PREDS predicate registers (<= 4, predicate 0 always true)
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   pc / instr                 fetch address and its instruction word
//   readreg0/1, in_reg0/1      operand register read port
//   reg_wen/waddr/wval         register write strobe
//   pred, pred_val             predicate read port
//   pred_wen/waddr/wval        predicate write strobe
//   mem_rd_req, readmem0,
//   mem_rd_valid, in_mem0      handshaked load
//   mem_wen/waddr/wval         store strobe
//   queue_wen, queue_number    dispatch-queue push
//   request_new_pc,
//   new_pc_valid, new_pc       new start-pc handshake
//
// Build option
//   SIMT_CORE_MUL_EN  when defined, opcode 2 multiplies; otherwise it is a NOP
//                     and no multiplier exists.
// ---------------------------------------------------------------------------
module simt_core_param #(
   parameter int DATA_W    = 16,
   parameter int PC_W      = 16,
   parameter int NUM_REGS  = 16,
   parameter int NUM_PREDS = 4
) (
   input  logic              clk,
   input  logic              rst,
   output logic [PC_W-1:0]   pc,
   input  logic [31:0]       instr,
   output logic [3:0]        readreg0,
   output logic [3:0]        readreg1,
   input  logic [DATA_W-1:0] in_reg0,
   input  logic [DATA_W-1:0] in_reg1,
   output logic              reg_wen,
   output logic [3:0]        reg_waddr,
   output logic [DATA_W-1:0] reg_wval,
   output logic [1:0]        pred,
   input  logic              pred_val,
   output logic              pred_wen,
   output logic [1:0]        pred_waddr,
   output logic              pred_wval,
   output logic              mem_rd_req,
   output logic [DATA_W-1:0] readmem0,
   input  logic              mem_rd_valid,
   input  logic [DATA_W-1:0] in_mem0,
   output logic              mem_wen,
   output logic [DATA_W-1:0] mem_waddr,
   output logic [DATA_W-1:0] mem_wval,
   output logic              queue_wen,
   output logic [3:0]        queue_number,
   output logic              request_new_pc,
   input  logic              new_pc_valid,
   input  logic [PC_W-1:0]   new_pc
);

   typedef enum logic [2:0] {WAIT_PC, DECODE, READ, MEM, EXEC} state_t;

   localparam logic [4:0] OP_LD   = 5'd0;
   localparam logic [4:0] OP_ST   = 5'd1;
   localparam logic [4:0] OP_MUL  = 5'd2;
   localparam logic [4:0] OP_ADD  = 5'd3;
   localparam logic [4:0] OP_SUB  = 5'd4;
   localparam logic [4:0] OP_SHR  = 5'd5;
   localparam logic [4:0] OP_SHL  = 5'd6;
   localparam logic [4:0] OP_AND  = 5'd7;
   localparam logic [4:0] OP_NOT  = 5'd8;
   localparam logic [4:0] OP_XOR  = 5'd9;
   localparam logic [4:0] OP_OR   = 5'd10;
   localparam logic [4:0] OP_NAND = 5'd11;
   localparam logic [4:0] OP_LDI  = 5'd12;
   localparam logic [4:0] OP_SETP = 5'd13;
   localparam logic [4:0] OP_QREG = 5'd14;
   localparam logic [4:0] OP_QIMM = 5'd15;
   localparam logic [4:0] OP_DONE = 5'd16;
   localparam logic [4:0] OP_BRA  = 5'd17;

   // Register fields are 4 bits wide; smaller register files alias the upper indices.
   function automatic logic [3:0] wrapReg(input logic [3:0] idx);
      wrapReg = 4'(int'(idx) % NUM_REGS);
   endfunction

   state_t              r_state;
   state_t              w_nextState;
   logic [PC_W-1:0]     r_pc;
   logic [1:0]          r_psel;
   logic                r_pinv;
   logic [4:0]          r_op;
   logic [3:0]          r_ra;
   logic [3:0]          r_rb;
   logic [3:0]          r_rd;
   logic [15:0]         r_imm;
   logic [DATA_W-1:0]   r_reg0;
   logic [DATA_W-1:0]   r_reg1;
   logic [DATA_W-1:0]   r_mem;
   logic                r_en;
   logic                r_regWen;
   logic [3:0]          r_regWaddr;
   logic [DATA_W-1:0]   r_regWval;
   logic                r_predWen;
   logic [1:0]          r_predWaddr;
   logic                r_predWval;
   logic                r_memWen;
   logic [DATA_W-1:0]   r_memWaddr;
   logic [DATA_W-1:0]   r_memWval;
   logic                r_queueWen;
   logic [3:0]          r_queueNumber;

   logic                w_en;
   logic                w_doRegWr;
   logic [DATA_W-1:0]   w_regVal;
   logic                w_doPredWr;
   logic                w_doMemWr;
   logic                w_doQueueWr;
   logic [3:0]          w_queueNum;

   // Predicate 0 reads as true without consulting the predicate file.
   assign w_en = ((r_psel == 2'd0) ? 1'b1 : pred_val) ^ r_pinv;

   assign pc             = r_pc;
   assign readreg0       = wrapReg(r_ra);
   assign readreg1       = wrapReg(r_rb);
   assign pred           = r_psel;
   assign request_new_pc = (r_state == WAIT_PC);
   assign mem_rd_req     = (r_state == MEM);
   assign readmem0       = mem_rd_req ? r_reg0 : '0;
   assign reg_wen        = r_regWen;
   assign reg_waddr      = r_regWaddr;
   assign reg_wval       = r_regWval;
   assign pred_wen       = r_predWen;
   assign pred_waddr     = r_predWaddr;
   assign pred_wval      = r_predWval;
   assign mem_wen        = r_memWen;
   assign mem_waddr      = r_memWaddr;
   assign mem_wval       = r_memWval;
   assign queue_wen      = r_queueWen;
   assign queue_number   = r_queueNumber;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= WAIT_PC;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. A load only detours through MEM when it is enabled;
   // only an enabled DONE returns to WAIT_PC.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         WAIT_PC: if (new_pc_valid) w_nextState = DECODE;
         DECODE:  w_nextState = READ;
         READ:    w_nextState = (r_op == OP_LD && w_en) ? MEM : EXEC;
         MEM:     if (mem_rd_valid) w_nextState = EXEC;
         EXEC:    w_nextState = (r_en && r_op == OP_DONE) ? WAIT_PC : DECODE;
         default: w_nextState = WAIT_PC;
      endcase
   end

   // Execute-stage result selection from the latched operands. A disabled
   // instruction produces no write of any kind.
   always_comb begin
      w_doRegWr   = 1'b0;
      w_regVal    = '0;
      w_doPredWr  = 1'b0;
      w_doMemWr   = 1'b0;
      w_doQueueWr = 1'b0;
      w_queueNum  = 4'd0;
      if (r_en) begin
         case (r_op)
            OP_LD:   begin w_doRegWr = 1'b1; w_regVal = r_mem; end
            OP_ST:   w_doMemWr = 1'b1;
`ifdef SIMT_CORE_MUL_EN
            OP_MUL:  begin w_doRegWr = 1'b1; w_regVal = r_reg0 * r_reg1; end
`endif
            OP_ADD:  begin w_doRegWr = 1'b1; w_regVal = r_reg0 + r_reg1; end
            OP_SUB:  begin w_doRegWr = 1'b1; w_regVal = r_reg0 - r_reg1; end
            OP_SHR:  begin w_doRegWr = 1'b1; w_regVal = r_reg0 >> r_reg1; end
            OP_SHL:  begin w_doRegWr = 1'b1; w_regVal = r_reg0 << r_reg1; end
            OP_AND:  begin w_doRegWr = 1'b1; w_regVal = r_reg0 & r_reg1; end
            OP_NOT:  begin w_doRegWr = 1'b1; w_regVal = DATA_W'(r_reg0 == '0); end
            OP_XOR:  begin w_doRegWr = 1'b1; w_regVal = r_reg0 ^ r_reg1; end
            OP_OR:   begin w_doRegWr = 1'b1; w_regVal = r_reg0 | r_reg1; end
            OP_NAND: begin w_doRegWr = 1'b1; w_regVal = ~(r_reg0 & r_reg1); end
            OP_LDI:  begin w_doRegWr = 1'b1; w_regVal = DATA_W'(r_imm); end
            OP_SETP: w_doPredWr = (r_rd[1:0] != 2'd0) && (int'(r_rd[1:0]) < NUM_PREDS);
            OP_QREG: begin w_doQueueWr = 1'b1; w_queueNum = r_reg0[3:0]; end
            OP_QIMM: begin w_doQueueWr = 1'b1; w_queueNum = r_imm[3:0]; end
            default: ;
         endcase
      end
   end

   // Datapath: pc, latched fields and operands, and the write strobes. Strobes
   // default low every cycle so each one lives exactly one cycle after EXEC.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc          <= '0;
         r_psel        <= 2'd0;
         r_pinv        <= 1'b0;
         r_op          <= 5'd0;
         r_ra          <= 4'd0;
         r_rb          <= 4'd0;
         r_rd          <= 4'd0;
         r_imm         <= 16'd0;
         r_reg0        <= '0;
         r_reg1        <= '0;
         r_mem         <= '0;
         r_en          <= 1'b0;
         r_regWen      <= 1'b0;
         r_regWaddr    <= 4'd0;
         r_regWval     <= '0;
         r_predWen     <= 1'b0;
         r_predWaddr   <= 2'd0;
         r_predWval    <= 1'b0;
         r_memWen      <= 1'b0;
         r_memWaddr    <= '0;
         r_memWval     <= '0;
         r_queueWen    <= 1'b0;
         r_queueNumber <= 4'd0;
      end else begin
         r_regWen   <= 1'b0;
         r_predWen  <= 1'b0;
         r_memWen   <= 1'b0;
         r_queueWen <= 1'b0;
         case (r_state)
            WAIT_PC: if (new_pc_valid) r_pc <= new_pc;
            DECODE: begin
               r_psel <= instr[31:30];
               r_pinv <= instr[29];
               r_op   <= instr[28:24];
               r_ra   <= instr[23:20];
               r_rb   <= instr[19:16];
               r_rd   <= instr[15:12];
               r_imm  <= instr[15:0];
            end
            READ: begin
               r_reg0 <= in_reg0;
               r_reg1 <= in_reg1;
               r_en   <= w_en;
            end
            MEM: if (mem_rd_valid) r_mem <= in_mem0;
            EXEC: begin
               r_regWen   <= w_doRegWr;
               r_predWen  <= w_doPredWr;
               r_memWen   <= w_doMemWr;
               r_queueWen <= w_doQueueWr;
               if (w_doRegWr) begin
                  r_regWaddr <= wrapReg(r_rd);
                  r_regWval  <= w_regVal;
               end
               if (w_doPredWr) begin
                  r_predWaddr <= r_rd[1:0];
                  r_predWval  <= (r_reg0 < r_reg1);
               end
               if (w_doMemWr) begin
                  r_memWaddr <= r_reg1;
                  r_memWval  <= r_reg0;
               end
               if (w_doQueueWr) begin
                  r_queueNumber <= w_queueNum;
               end
               if (r_en && r_op == OP_DONE) begin
                  r_pc <= r_pc;
               end else if (r_en && r_op == OP_BRA) begin
                  r_pc <= PC_W'(r_imm);
               end else begin
                  r_pc <= r_pc + PC_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/simt_core_param.md
# simt_core_param

Parametrised next-generation GPU thread core: fetches one 32-bit instruction per issue, reads two operands from an external register file, optionally waits for a handshaked memory load, executes, and writes back register, predicate, memory or dispatch-queue results. Adds synchronous reset, a configurable data width, predicate count and register count, predicate inversion, a handshaked load path, a branch opcode and a handshaked new-PC request to the earlier fixed-width core. One instance sits per thread slot, between the instruction memory, the shared register/predicate files, the data memory and the GPU dispatch queue.

## Interface
- DATA_W, 16: register, memory and immediate data width (≥16; imm zero-extended).
- PC_W, 16: program counter width.
- NUM_REGS, 16: architectural registers (≤16; fields are 4 bits, upper indices wrap modulo NUM_REGS).
- NUM_PREDS, 4: predicate registers (≤4; predicate 0 is hard-wired true).
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset: synchronous, active-high.
- pc  out  PC_W  current fetch address; instr is valid combinationally in the same cycle.
- instr  in  32  instruction word.
- readreg0 / readreg1  out  4  operand register addresses (ra, rb).
- in_reg0 / in_reg1  in  DATA_W  combinational register file read data.
- reg_wen, reg_waddr[4], reg_wval[DATA_W]  out  register write port.
- pred  out  2  predicate read select; pred_val  in  1  its value.
- pred_wen, pred_waddr[2], pred_wval[1]  out  predicate write port.
- mem_rd_req  out  1; readmem0  out  DATA_W  load address; mem_rd_valid  in  1; in_mem0  in  DATA_W.
- mem_wen, mem_waddr[DATA_W], mem_wval[DATA_W]  out  store port.
- queue_wen  out  1; queue_number  out  4  dispatch-queue push.
- request_new_pc  out  1; new_pc_valid  in  1; new_pc  in  PC_W.

## Operation
- Fields: [31:30] psel, [29] pinv, [28:24] opcode, [23:20] ra, [19:16] rb, [15:12] rd, [15:0] imm.
- States: WAIT_PC, DECODE, READ, MEM, EXEC.
- WAIT_PC: request_new_pc=1; on new_pc_valid: pc←new_pc, →DECODE.
- DECODE: latch all fields → READ.
- READ: readreg0=ra, readreg1=rb, pred=psel. Latch operands. Latch en = (psel==0 ? 1 : pred_val) XOR pinv. If opcode==0 && en → MEM, else → EXEC.
- MEM: mem_rd_req=1, readmem0=reg0val. Hold until mem_rd_valid; latch in_mem0 → EXEC.
- EXEC, if en: 0 LD rd←mem; 1 ST mem[reg1val]←reg0val; 2 MUL (low DATA_W bits); 3 ADD; 4 SUB (wrap mod 2^DATA_W); 5 SHR / 6 SHL (logical, shift ≥DATA_W gives 0); 7 AND; 8 NOT (logical: 1 if reg0val==0, else 0); 9 XOR; 10 OR; 11 NAND; 12 LDI rd←imm; 13 SETP pred[rd[1:0]]←(reg0val<reg1val unsigned); 14 QREG queue←reg0val[3:0]; 15 QIMM queue←imm[3:0]; 16 DONE →WAIT_PC; 17 BRA pc←imm[PC_W-1:0]. Opcodes 18–31 are NOP.
- SETP to predicate 0, or to an index ≥NUM_PREDS: no write.
- If en=0: no write strobes, pc←pc+1 (DONE and BRA suppressed).
- Otherwise pc←pc+1 (pc wraps at 2^PC_W) → DECODE, except DONE (pc held) and BRA.

## Timing
- Reset: state WAIT_PC; pc=0; all wen/queue_wen/mem_rd_req=0; addresses and data outputs 0; request_new_pc=1 in the first cycle after reset.
- Reset asserted mid-instruction aborts it: no strobe issues, and a pending load is dropped.
- Write strobes are registered at the EXEC edge, high for exactly one cycle (the next DECODE), then cleared.
- Latency, non-load: 3 cycles per instruction (DECODE, READ, EXEC).
- Latency, load: 3 + N cycles, where N ≥ 1 is the number of MEM cycles up to and including mem_rd_valid.
- mem_rd_req and readmem0 stay stable until mem_rd_valid. mem_rd_valid outside MEM is ignored.
- new_pc_valid outside WAIT_PC is ignored. new_pc_valid in the first WAIT_PC cycle is accepted, so WAIT_PC lasts a minimum of 1 cycle.
- A register written by instruction k is readable by instruction k+1, since its READ follows the strobe cycle.

## Configuration
- SIMT_CORE_MUL_EN defined: opcode 2 is a DATA_W×DATA_W multiply truncated to DATA_W.
- Not defined: no multiplier is synthesised, and opcode 2 is a NOP (no reg_wen; pc advances).

## Test plan
- Reset, then new_pc=0x0010 with new_pc_valid in cycle 2. Required: request_new_pc=1 until accept, pc=0x0010, every strobe 0 throughout.
- LDI r1←5; LDI r2←3; SUB r3=r2−r1. Required: reg_wval for r3 = 0xFFFE (DATA_W=16); each instruction takes 3 cycles.
- LD r4 with mem_rd_valid delayed 4 cycles, in_mem0=0xBEEF. Required: mem_rd_req held 4 cycles with readmem0 stable; reg_wval for r4 = 0xBEEF one cycle later.
- SETP p1 with 2<7, then ADD with psel=1 pinv=1. Required: pred_wval=1 for p1; the ADD issues no reg_wen and pc increments.
- BRA imm=0x0040 taken, then DONE. Required: pc=0x0040; DONE asserts request_new_pc with pc held.
- Assert rst during MEM. Required: no reg_wen; pc=0; state WAIT_PC.
